ball_motion_ctl: RTL

Game-logic block that produces the ball position consumed by the ball/pad renderer.
- Moves the ball once per video frame.
- Bounces it off the top and bottom walls and off both pads.
- Detects misses, issues point pulses and holds the ball before re-centring for the next serve.
- Sits between the pad-position sources and the drawing stage; shares playfield geometry with it.

---
 rtl/pong_pkg.sv | 58 +++++
 rtl/ball_motion_ctl_pad_collide.sv | 64 ++++++
 rtl/ball_motion_ctl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// -----------------------------------------------------------------------------
// pong_pkg
// Shared playfield geometry and game-logic types for the pong datapath.
// The renderer imports the same geometry constants, so the ball position
// produced by ball_motion_ctl and the drawing stage always agree on where
// walls, pads and the ball extent are.
//
// Contents:
//   - geometry: H_ACTIVE, V_ACTIVE, BALL_SIZE, PAD_HEIGHT, PAD_WIDTH,
//     X_PAD_LEFT, X_PAD_RIGHT
//   - motion tuning: SPEED_INIT, SPEED_MAX, SCORE_HOLD
//   - derived limits: X_MAX, Y_MAX, LFACE, X_CENTRE, Y_CENTRE
//   - state_e : ball controller states {IDLE, MOVE, SCORE}
//   - dir_t   : one-bit direction flag with named values per axis
// -----------------------------------------------------------------------------
package pong_pkg;

  // Playfield geometry
  localparam int H_ACTIVE    = 1024;
  localparam int V_ACTIVE    = 768;
  localparam int BALL_SIZE   = 15;   // ball spans x..x+BALL_SIZE inclusive
  localparam int PAD_HEIGHT  = 145;  // pad spans y_pad..y_pad+PAD_HEIGHT
  localparam int PAD_WIDTH   = 15;   // pad spans x_pad..x_pad+PAD_WIDTH
  localparam int X_PAD_LEFT  = 30;
  localparam int X_PAD_RIGHT = 979;

  // Motion tuning
  localparam int SPEED_INIT  = 4;
  localparam int SPEED_MAX   = 12;
  localparam int SCORE_HOLD  = 60;

  // Derived limits for the ball's top-left corner
  localparam int X_MAX    = H_ACTIVE - 1 - BALL_SIZE;   // 1008
  localparam int Y_MAX    = V_ACTIVE - 1 - BALL_SIZE;   // 752
  localparam int LFACE    = X_PAD_LEFT + PAD_WIDTH;     // 45, left pad front face
  localparam int X_CENTRE = X_MAX / 2;                  // 504
  localparam int Y_CENTRE = Y_MAX / 2;                  // 376

  // Controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MOVE  = 2'd1,
    SCORE = 2'd2
  } state_e;

  // Direction flag. Horizontal uses DX_*, vertical uses DY_*.
  typedef logic dir_t;
  localparam dir_t DX_LEFT  = 1'b0;
  localparam dir_t DX_RIGHT = 1'b1;
  localparam dir_t DY_DOWN  = 1'b0;
  localparam dir_t DY_UP    = 1'b1;

  // Zero-extend an 11-bit coordinate into the 12-bit compare domain.
  function automatic logic [11:0] ext12(input logic [10:0] v);
    return {1'b0, v};
  endfunction

endpackage

// File: rtl/ball_motion_ctl_pad_collide.sv
// -----------------------------------------------------------------------------
// pad_collide
// Combinational collision test between the ball and one pad for the frame
// step that is about to happen. Instantiated once per side.
//
// Ports:
//   x, y    in  11  current registered ball top-left corner
//   speed   in  4   current per-axis step
//   y_pad   in  10  pad top row
//   side    in  1   DX_LEFT or DX_RIGHT: which pad this instance models
//   hit     out 1   the step would cross the pad face while overlapping it
//   miss    out 1   no hit, and the step would carry the ball past the edge
//
// All compares run in 12 bits with zero-extended inputs, so nothing wraps.
// The left-side "x - speed <= LFACE" test is written as "x <= LFACE + speed"
// to stay in unsigned arithmetic without underflow.
// -----------------------------------------------------------------------------
module pad_collide
  import pong_pkg::*;
(
  input  logic [10:0] x,
  input  logic [10:0] y,
  input  logic [3:0]  speed,
  input  logic [9:0]  y_pad,
  input  dir_t        side,
  output logic        hit,
  output logic        miss
);

  logic [11:0] x12;
  logic [11:0] y12;
  logic [11:0] s12;
  logic [11:0] p12;
  logic [11:0] x_right_edge;
  logic        overlap;

  assign x12          = ext12(x);
  assign y12          = ext12(y);
  assign s12          = {8'd0, speed};
  assign p12          = {2'd0, y_pad};
  assign x_right_edge = x12 + 12'(BALL_SIZE);

  // Vertical overlap uses the pre-update ball row.
  assign overlap = (y12 + 12'(BALL_SIZE) >= p12) &&
                   (y12 <= p12 + 12'(PAD_HEIGHT));

  always_comb begin
    hit  = 1'b0;
    miss = 1'b0;
    if (side == DX_LEFT) begin
      // Ball is still in front of the face and this step reaches it.
      hit  = (x12 > 12'(LFACE)) &&
             (x12 <= 12'(LFACE) + s12) &&
             overlap;
      miss = !hit && (x12 < s12);
    end else begin
      hit  = (x_right_edge < 12'(X_PAD_RIGHT)) &&
             (x_right_edge + s12 >= 12'(X_PAD_RIGHT)) &&
             overlap;
      miss = !hit && (x12 + s12 > 12'(X_MAX));
    end
  end

endmodule

// File: rtl/ball_motion_ctl.sv
// -----------------------------------------------------------------------------
// ball_motion_ctl
// Moves the pong ball once per video frame, bounces it off the top/bottom
// walls and both pads, detects misses, pulses the scoring player's point
// output and holds the ball frozen for SCORE_HOLD frames before re-centring
// it for the next serve.
//
// Ports:
//   clk          in  1   pixel clock
//   rst          in  1   synchronous reset, active-high
//   frame_tick   in  1   one-cycle pulse per frame (start of vblank)
//   serve        in  1   start request, only looked at in IDLE
//   serve_dir    in  1   0 = launch leftward, 1 = rightward
//   y_pad_left   in  10  left pad top row
//   y_pad_right  in  10  right pad top row
//   x_ball       out 11  ball left column (registered)
//   y_ball       out 11  ball top row (registered)
//   ball_active  out 1   high while the ball is in play (MOVE)
//   point_left   out 1   one-cycle pulse: left player scored
//   point_right  out 1   one-cycle pulse: right player scored
//   speed        out 4   current per-axis step size
//   state_dbg    out 2   controller state (IDLE=0, MOVE=1, SCORE=2)
//
// In MOVE both axes are evaluated from the current registered values on a
// frame_tick cycle and committed together, so a pad hit and a wall bounce in
// the same frame are both applied. The ball never leaves 0..X_MAX / 0..Y_MAX.
// -----------------------------------------------------------------------------
module ball_motion_ctl
  import pong_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        serve,
  input  logic        serve_dir,
  input  logic [9:0]  y_pad_left,
  input  logic [9:0]  y_pad_right,
  output logic [10:0] x_ball,
  output logic [10:0] y_ball,
  output logic        ball_active,
  output logic        point_left,
  output logic        point_right,
  output logic [3:0]  speed,
  output logic [1:0]  state_dbg
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_MOVE  = MOVE;
  localparam logic [1:0] S_SCORE = SCORE;

  localparam logic [10:0] X_CENTRE_V   = 11'(X_CENTRE);
  localparam logic [10:0] Y_CENTRE_V   = 11'(Y_CENTRE);
  localparam logic [10:0] X_MAX_V      = 11'(X_MAX);
  localparam logic [10:0] Y_MAX_V      = 11'(Y_MAX);
  localparam logic [10:0] X_BOUNCE_L   = 11'(LFACE + 1);                    // 46
  localparam logic [10:0] X_BOUNCE_R   = 11'(X_PAD_RIGHT - BALL_SIZE - 1);  // 963
  localparam logic [3:0]  SPEED_INIT_V = 4'(SPEED_INIT);
  localparam logic [3:0]  SPEED_MAX_V  = 4'(SPEED_MAX);
  localparam logic [5:0]  HOLD_LAST    = 6'(SCORE_HOLD - 1);

  logic [1:0] state;
  dir_t       dx;
  dir_t       dy;
  logic [5:0] hold_cnt;

  // Collision results for the frame step about to be taken
  logic hit_l;
  logic miss_l;
  logic hit_r;
  logic miss_r;

  // Next-frame candidates, committed only on a MOVE frame_tick
  logic [10:0] x_nxt;
  logic [10:0] y_nxt;
  dir_t        dx_nxt;
  dir_t        dy_nxt;
  logic [3:0]  speed_nxt;
  logic [3:0]  speed_bump;
  logic        score_l;
  logic        score_r;

  assign state_dbg = state;

  pad_collide u_collide_left (
    .x     (x_ball),
    .y     (y_ball),
    .speed (speed),
    .y_pad (y_pad_left),
    .side  (DX_LEFT),
    .hit   (hit_l),
    .miss  (miss_l)
  );

  pad_collide u_collide_right (
    .x     (x_ball),
    .y     (y_ball),
    .speed (speed),
    .y_pad (y_pad_right),
    .side  (DX_RIGHT),
    .hit   (hit_r),
    .miss  (miss_r)
  );

  // Every pad hit speeds the ball up, saturating at SPEED_MAX.
  assign speed_bump = (speed >= SPEED_MAX_V) ? SPEED_MAX_V : speed + 4'd1;

  // Vertical axis: reflect off the top and bottom walls, clamping the row.
  always_comb begin
    y_nxt  = y_ball;
    dy_nxt = dy;
    if (dy == DY_UP) begin
      if (ext12(y_ball) < {8'd0, speed}) begin
        y_nxt  = 11'd0;
        dy_nxt = DY_DOWN;
      end else begin
        y_nxt  = y_ball - {7'd0, speed};
      end
    end else begin
      if (ext12(y_ball) + {8'd0, speed} > ext12(Y_MAX_V)) begin
        y_nxt  = Y_MAX_V;
        dy_nxt = DY_UP;
      end else begin
        y_nxt  = y_ball + {7'd0, speed};
      end
    end
  end

  // Horizontal axis: only the pad the ball is travelling towards matters.
  always_comb begin
    x_nxt     = x_ball;
    dx_nxt    = dx;
    speed_nxt = speed;
    score_l   = 1'b0;
    score_r   = 1'b0;
    if (dx == DX_LEFT) begin
      if (hit_l) begin
        x_nxt     = X_BOUNCE_L;
        dx_nxt    = DX_RIGHT;
        speed_nxt = speed_bump;
      end else if (miss_l) begin
        x_nxt     = 11'd0;
        score_r   = 1'b1;
      end else begin
        x_nxt     = x_ball - {7'd0, speed};
      end
    end else begin
      if (hit_r) begin
        x_nxt     = X_BOUNCE_R;
        dx_nxt    = DX_LEFT;
        speed_nxt = speed_bump;
      end else if (miss_r) begin
        x_nxt     = X_MAX_V;
        score_l   = 1'b1;
      end else begin
        x_nxt     = x_ball + {7'd0, speed};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      x_ball      <= X_CENTRE_V;
      y_ball      <= Y_CENTRE_V;
      dx          <= DX_LEFT;
      dy          <= DY_DOWN;
      speed       <= SPEED_INIT_V;
      ball_active <= 1'b0;
      point_left  <= 1'b0;
      point_right <= 1'b0;
      hold_cnt    <= 6'd0;
    end else begin
      // Point outputs are single-cycle strobes.
      point_left  <= 1'b0;
      point_right <= 1'b0;
      case (state)
        S_IDLE: begin
          // A coincident frame_tick only launches; the first step waits
          // for the next frame.
          if (serve) begin
            state       <= S_MOVE;
            dx          <= serve_dir;
            dy          <= DY_DOWN;
            speed       <= SPEED_INIT_V;
            ball_active <= 1'b1;
          end
        end
        S_MOVE: begin
          if (frame_tick) begin
            x_ball <= x_nxt;
            y_ball <= y_nxt;
            dx     <= dx_nxt;
            dy     <= dy_nxt;
            speed  <= speed_nxt;
            if (score_l || score_r) begin
              state       <= S_SCORE;
              ball_active <= 1'b0;
              hold_cnt    <= 6'd0;
              point_left  <= score_l;
              point_right <= score_r;
            end
          end
        end
        S_SCORE: begin
          // Ball frozen where it left the field; serve is ignored here.
          if (frame_tick) begin
            if (hold_cnt == HOLD_LAST) begin
              state    <= S_IDLE;
              hold_cnt <= 6'd0;
              x_ball   <= X_CENTRE_V;
              y_ball   <= Y_CENTRE_V;
              dy       <= DY_DOWN;
              speed    <= SPEED_INIT_V;
            end else begin
              hold_cnt <= hold_cnt + 6'd1;
            end
          end
        end
        default: begin
          state       <= S_IDLE;
          ball_active <= 1'b0;
        end
      endcase
    end
  end

endmodule
